pixel_stream_source: RTL
========================

PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 Parameter WIDTH, default 400: active pixels per line.
REQ-002 Parameter HEIGHT, default 336: active lines per frame.
REQ-003 Parameter H_BLANK, default 2: blanking cycles after every line.
REQ-004 Parameter V_BLANK, default 4: extra blanking cycles after the last line of a frame.
REQ-005 Port list, one entry per port, SHALL be:
- clock, input, 1 bit: the single clock; all logic samples on its rising edge.
- reset, input, 1 bit: asynchronous, active-low reset.
- enable, input, 1 bit: level request to stream frames.
- pixel_in, input, 8 bits: upstream pixel.
- pixel_in_valid, input, 1 bit: pixel_in is present.
- pixel_in_ready, output, 1 bit: block accepts pixel_in this cycle.
- dout, output, 8 bits: pixel to the window filter.
- blanking_out, output, 1 bit: current output cycle is blanking.
- validout, output, 1 bit: dout/blanking_out are meaningful this cycle.
- frame_start, output, 1 bit: one-cycle pulse on the first pixel of a frame.
- underrun, output, 1 bit: sticky flag, upstream starved during an active line.

Function
REQ-006 FSM states SHALL be IDLE, ACTIVE, HBLANK, VBLANK.
REQ-007 IDLE -> ACTIVE SHALL occur on the first clock edge where enable=1; col and row SHALL be 0 on entry.
REQ-008 pixel_in_ready SHALL be combinational: 1 only in state ACTIVE, otherwise 0.
REQ-009 A pixel SHALL be accepted when pixel_in_valid=1 and pixel_in_ready=1 on the same edge.
REQ-010 Output latency SHALL be 1 cycle: an accepted pixel appears on dout the next cycle, with validout=1 and blanking_out=0.
REQ-011 Each acceptance SHALL increment col.
REQ-012 On acceptance with col=WIDTH-1, the block SHALL reset col to 0 and go to HBLANK.
REQ-013 Underrun, i.e. ACTIVE with pixel_in_valid=0:
- next cycle validout=0, blanking_out=0, dout holds its last value;
- col and row SHALL NOT advance;
- underrun SHALL set to 1.
REQ-014 HBLANK SHALL last exactly H_BLANK cycles; each such cycle SHALL produce, one cycle later, validout=1, blanking_out=1, dout=0.
REQ-015 Leaving HBLANK:
- if row<HEIGHT-1: increment row and return to ACTIVE;
- otherwise: row:=0, go to VBLANK.
REQ-016 VBLANK SHALL last exactly V_BLANK cycles with the same output encoding as HBLANK; when V_BLANK=0 the FSM SHALL skip VBLANK.
REQ-017 At the end of VBLANK, the FSM SHALL go to ACTIVE if enable=1, else to IDLE.
REQ-018 Deasserting enable mid-frame SHALL NOT truncate the frame; the frame completes through VBLANK.
REQ-019 frame_start SHALL be 1 in exactly the output cycle carrying pixel (row 0, col 0).
REQ-020 In IDLE, outputs SHALL be validout=0, blanking_out=0, dout=0.
REQ-021 underrun SHALL clear only on reset.
REQ-022 Counter widths SHALL be $clog2 of their range; a wrap SHALL occur only at the limits above, never by overflow.
REQ-023 Frame cycle count with no underrun SHALL be HEIGHT*(WIDTH+H_BLANK)+V_BLANK; for the defaults this is 336*402+4 = 135076.

Reset
REQ-024 reset=0 SHALL immediately force:
- state=IDLE, col=0, row=0;
- dout=0, validout=0, blanking_out=0, frame_start=0, underrun=0;
- pixel_in_ready=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame.
REQ-026 After reset is released, the next frame SHALL begin at (0,0) no earlier than the first edge with enable=1.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Continuous stream: pixel_in_valid=1, pixel_in = counter 0,1,2..., enable=1 -> dout sequence 0..399, then 2 cycles blanking_out=1 with dout=0, then 400..799; frame_start at the output of pixel 0 only.
- Full frame, defaults: 135076 cycles from the first ACTIVE cycle to the next frame_start; blanking_out=1 on exactly 336*2+4 = 676 output cycles.
- Underrun: drop pixel_in_valid for 3 cycles at col 10 -> 3 cycles with validout=0, underrun=1 sticky, dout resumes with pixel 10 and no pixel lost.
- Enable low at row 100 -> frame finishes through VBLANK, then IDLE with validout=0 and pixel_in_ready=0.
- Reset pulse at row 5, col 200 -> all outputs 0 within the same cycle; after release with enable=1, frame_start precedes pixel (0,0).
- Parameters WIDTH=4, HEIGHT=2, H_BLANK=1, V_BLANK=0 -> output pattern P P P P B P P P P B, repeating.

Source files
------------

// File: rtl/pixel_stream_source.sv
// Frame/line pacer: gates upstream pixels into WIDTH x HEIGHT frames with H/V blanking; 1-cycle output latency.
// Backpressure: pixel_in_ready is high only while a line is active; a starved active cycle emits validout=0 and sets sticky underrun.
module pixel_stream_source #(
    parameter int WIDTH   = 400,
    parameter int HEIGHT  = 336,
    parameter int H_BLANK = 2,
    parameter int V_BLANK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic       pixel_in_ready,
    output logic [7:0] dout,
    output logic       blanking_out,
    output logic       validout,
    output logic       frame_start,
    output logic       underrun
);

    localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BMAX  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [BW-1:0] H_LAST   = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BW-1:0] V_LAST   = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          accept;
    logic          line_end;

    logic [7:0]    dout_nxt;
    logic          blank_nxt;
    logic          vld_nxt;
    logic          fs_nxt;
    logic          underrun_nxt;

    assign accept = pixel_in_valid && pixel_in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            bcnt         <= '0;
            dout         <= '0;
            blanking_out <= 1'b0;
            validout     <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_nxt;
            col          <= col_nxt;
            row          <= row_nxt;
            bcnt         <= bcnt_nxt;
            dout         <= dout_nxt;
            blanking_out <= blank_nxt;
            validout     <= vld_nxt;
            frame_start  <= fs_nxt;
            underrun     <= underrun_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        bcnt_nxt  = bcnt;
        line_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = ACTIVE;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (col == COL_LAST) begin
                        col_nxt  = '0;
                        bcnt_nxt = '0;
                        if (H_BLANK > 0) state_nxt = HBLANK;
                        else             line_end  = 1'b1;
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end
            end
            HBLANK: begin
                if (bcnt == H_LAST) line_end = 1'b1;
                else                bcnt_nxt = bcnt + BW'(1);
            end
            VBLANK: begin
                if (bcnt == V_LAST) begin
                    bcnt_nxt  = '0;
                    state_nxt = enable ? ACTIVE : IDLE;
                end else begin
                    bcnt_nxt = bcnt + BW'(1);
                end
            end
        endcase
        // Shared end-of-line decision so H_BLANK=0 behaves like a zero-length HBLANK.
        if (line_end) begin
            bcnt_nxt = '0;
            if (row != ROW_LAST) begin
                row_nxt   = row + RW'(1);
                state_nxt = ACTIVE;
            end else begin
                row_nxt = '0;
                if (V_BLANK > 0) state_nxt = VBLANK;
                else             state_nxt = enable ? ACTIVE : IDLE;
            end
        end
    end

    always_comb begin
        pixel_in_ready = (state == ACTIVE);
        dout_nxt       = '0;
        blank_nxt      = 1'b0;
        vld_nxt        = 1'b0;
        fs_nxt         = 1'b0;
        underrun_nxt   = underrun;
        unique case (state)
            IDLE: ;
            ACTIVE: begin
                if (accept) begin
                    dout_nxt = pixel_in;
                    vld_nxt  = 1'b1;
                    fs_nxt   = (row == '0) && (col == '0);
                end else begin
                    dout_nxt     = dout;
                    underrun_nxt = 1'b1;
                end
            end
            HBLANK, VBLANK: begin
                vld_nxt   = 1'b1;
                blank_nxt = 1'b1;
            end
        endcase
    end

endmodule
